// File: rtl/sa_pkg.sv
// Shared widths and types for the systolic-array matrix engine.
package sa_pkg;
   localparam int DATA_W = 4;
   localparam int PROD_W = 2 * DATA_W;
   localparam int PSUM_W = 12;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [PROD_W-1:0] prod_t;
   typedef logic [PSUM_W-1:0] psum_t;
endpackage

// File: rtl/sa_pe_if.sv
// PE data/control bundle: master drives the PE inputs, slave is the PE itself.
interface sa_pe_if;
   import sa_pkg::*;

   logic  PE_enable;
   logic  load_weight;
   logic  out_model;
   logic  is_signed;
   psum_t input_top;
   data_t input_left;
   psum_t out_bot;
   data_t out_right;

   modport master (
      output PE_enable, load_weight, out_model, is_signed, input_top, input_left,
      input  out_bot, out_right
   );

   modport slave (
      input  PE_enable, load_weight, out_model, is_signed, input_top, input_left,
      output out_bot, out_right
   );
endinterface

// File: rtl/sa_pe_mult.sv
// Combinational 4x4 multiplier, signed or unsigned; 0 cycles, no flow control.
module sa_pe_mult
   import sa_pkg::*;
(
   input  data_t a,
   input  data_t b,
   input  logic  is_signed,
   output prod_t product
);
   prod_t a_ext;
   prod_t b_ext;

   // Extending both operands to the product width makes a truncated product
   // correct for both signed and unsigned interpretation.
   assign a_ext   = {{(PROD_W-DATA_W){is_signed & a[DATA_W-1]}}, a};
   assign b_ext   = {{(PROD_W-DATA_W){is_signed & b[DATA_W-1]}}, b};
   assign product = a_ext * b_ext;
endmodule

// File: rtl/sa_pe.sv
// Weight-stationary PE: out_bot = top (+ weight*left), out_right = left; 1-cycle latency.
// No backpressure; PE_enable=0 freezes all registers.
module sa_pe
   import sa_pkg::*;
(
   input logic   clk,
   input logic   reset,
   sa_pe_if.slave pe
);
   data_t weight;
   psum_t out_bot_q;
   data_t out_right_q;
   prod_t mult_pro;
   psum_t prod_ext;

   sa_pe_mult u_mult (
      .a         (weight),
      .b         (pe.input_left),
      .is_signed (pe.is_signed),
      .product   (mult_pro)
   );

   assign prod_ext = {{(PSUM_W-PROD_W){pe.is_signed & mult_pro[PROD_W-1]}}, mult_pro};

   always_ff @(posedge clk) begin
      if (reset) begin
         weight      <= '0;
         out_bot_q   <= '0;
         out_right_q <= '0;
      end else if (pe.PE_enable) begin
         out_right_q <= pe.input_left;
         if (pe.load_weight) begin
            // Weight travels on with the psum bus so the column loads bottom-first.
            weight    <= pe.input_top[DATA_W-1:0];
            out_bot_q <= pe.input_top;
         end else if (pe.out_model) begin
            out_bot_q <= pe.input_top + prod_ext;
         end else begin
            out_bot_q <= pe.input_top;
         end
      end
   end

   assign pe.out_bot   = out_bot_q;
   assign pe.out_right = out_right_q;
endmodule

// File: tb/tb_sa_pe.sv
// Bench for sa_pe: directed cases plus random traffic against an arithmetic model.
module tb_sa_pe;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [3:0]  m_weight;
   logic [11:0] m_bot;
   logic [3:0]  m_right;
   bit          m_known = 1'b0;

   sa_pe_if pe_if ();

   sa_pe dut (
      .clk   (clk),
      .reset (reset),
      .pe    (pe_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int prod_val(input logic [3:0] w, input logic [3:0] a, input bit sg);
      int sw;
      int sa;
      sw = int'(w);
      sa = int'(a);
      if (sg) begin
         if (w > 4'd7) sw = sw - 16;
         if (a > 4'd7) sa = sa - 16;
      end
      return sw * sa;
   endfunction

   task automatic step(input bit rst, input bit en, input bit ld, input bit om, input bit sg,
                       input logic [11:0] top, input logic [3:0] left);
      logic [31:0] p;
      logic [31:0] sum;
      reset             = rst;
      pe_if.PE_enable   = en;
      pe_if.load_weight = ld;
      pe_if.out_model   = om;
      pe_if.is_signed   = sg;
      pe_if.input_top   = top;
      pe_if.input_left  = left;
      #1;
      p = prod_val(m_weight, left, sg);
      if (m_known) check("mult_pro", {24'h0, dut.mult_pro}, {24'h0, p[7:0]});
      @(posedge clk);
      if (rst) begin
         m_weight = 4'h0;
         m_bot    = 12'h000;
         m_right  = 4'h0;
         m_known  = 1'b1;
      end else if (en) begin
         m_right = left;
         if (ld) begin
            m_weight = top[3:0];
            m_bot    = top;
         end else if (om) begin
            sum   = {20'h0, top} + p;
            m_bot = sum[11:0];
         end else begin
            m_bot = top;
         end
      end
      #1;
      if (m_known) begin
         check("out_bot", {20'h0, pe_if.out_bot}, {20'h0, m_bot});
         check("out_right", {28'h0, pe_if.out_right}, {28'h0, m_right});
         check("weight", {28'h0, dut.weight}, {28'h0, m_weight});
      end
   endtask

   initial begin
      m_weight = 4'h0;
      m_bot    = 12'h0;
      m_right  = 4'h0;

      // Reset wins over load
      step(1, 1, 1, 0, 0, 12'hABC, 4'hF);
      check("rst_bot", {20'h0, pe_if.out_bot}, 32'h000);
      check("rst_weight", {28'h0, dut.weight}, 32'h0);

      // Unsigned 15*15
      step(0, 1, 1, 0, 0, 12'h00F, 4'h0);
      step(0, 1, 0, 1, 0, 12'h000, 4'hF);
      check("ub_e1", {20'h0, pe_if.out_bot}, 32'h0E1);

      // Hold while disabled, with inputs toggling
      step(0, 0, 1, 0, 1, 12'h777, 4'h3);
      step(0, 0, 0, 1, 0, 12'h888, 4'hC);
      step(0, 0, 1, 1, 1, 12'h999, 4'h5);
      check("hold_bot", {20'h0, pe_if.out_bot}, 32'h0E1);
      check("hold_right", {28'h0, pe_if.out_right}, 32'hF);
      check("hold_weight", {28'h0, dut.weight}, 32'hF);
      step(0, 1, 0, 1, 0, 12'h010, 4'h1);
      check("reen_bot", {20'h0, pe_if.out_bot}, 32'h01F);

      // Signed -1*2 versus unsigned 15*2
      step(0, 1, 0, 1, 1, 12'h000, 4'h2);
      check("s_fffe", {20'h0, pe_if.out_bot}, 32'hFFE);
      step(0, 1, 0, 1, 0, 12'h000, 4'h2);
      check("u_01e", {20'h0, pe_if.out_bot}, 32'h01E);

      // Signed extremes: -8*-8 = 64, 7*-8 = -56
      step(0, 1, 1, 0, 0, 12'h008, 4'h0);
      step(0, 1, 0, 1, 1, 12'h000, 4'h8);
      check("s_p64", {20'h0, pe_if.out_bot}, 32'h040);
      step(0, 1, 1, 0, 0, 12'h007, 4'h0);
      step(0, 1, 0, 1, 1, 12'h100, 4'h8);
      check("s_m56", {20'h0, pe_if.out_bot}, 32'h0C8);

      // Wrap and bypass
      step(0, 1, 1, 0, 0, 12'h001, 4'h0);
      step(0, 1, 0, 1, 0, 12'hFFF, 4'h1);
      check("wrap", {20'h0, pe_if.out_bot}, 32'h000);
      step(0, 1, 0, 0, 0, 12'h123, 4'h5);
      check("bypass", {20'h0, pe_if.out_bot}, 32'h123);

      // Load shift-through
      step(0, 1, 1, 1, 1, 12'h5A7, 4'h9);
      check("ld_weight", {28'h0, dut.weight}, 32'h7);
      check("ld_bot", {20'h0, pe_if.out_bot}, 32'h5A7);

      // Mid-operation reset discards the weight
      step(1, 0, 0, 1, 0, 12'h321, 4'h4);
      check("rst2_weight", {28'h0, dut.weight}, 32'h0);

      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 40) == 0, $urandom_range(0, 7) != 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              12'($urandom), 4'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
